gearbox_tx: RTL and testbench

- TX-side counterpart of the 10GBASE-R block-sync receiver: an external 64b/66b transmit gearbox.
- Accepts 66-bit blocks as a 2-bit sync header plus two 32-bit payload halves, paced by in_ready.
- Emits a continuous 32-bit word stream toward the serializer/GT running in raw 32-bit mode.
- Absorbs the 66:64 rate mismatch with a 33-cycle sequence counter: upstream pauses one cycle in every 33.

---
 rtl/gearbox_tx_if.sv | 11 +
 rtl/gearbox_tx.sv | 86 ++++++++
 tb/tb_gearbox_tx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gearbox_tx_if.sv
// Upstream block interface of the 64b/66b transmit gearbox.
// The gearbox paces the source with in_ready; the source presents one half-block per ready cycle.
interface gearbox_tx_if;
  logic        in_ready;
  logic [1:0]  header;
  logic        header_ena;
  logic [31:0] data;

  modport master (input in_ready, output header, output header_ena, output data);
  modport slave  (output in_ready, input header, input header_ena, input data);
endinterface

// File: rtl/gearbox_tx.sv
// External 64b/66b TX gearbox: packs 66-bit blocks into a continuous 32-bit stream.
// A mod-33 sequence counter stalls upstream once per period to absorb the 66:64 mismatch.
module gearbox_tx #(
  parameter bit BIT_REVERSE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  gearbox_tx_if.slave  up,
  output logic [31:0]  tx_data,
  output logic         tx_valid,
  output logic [5:0]   seq,
  output logic         phase_err
);

  logic [63:0] bits_q;
  logic [63:0] bits_d;
  logic [6:0]  fill_q;
  logic [6:0]  fill_d;
  logic [6:0]  new_len;
  logic [6:0]  win_len;
  logic [6:0]  rest_len;
  logic        exp_first_q;
  logic        accept;
  logic        emit;
  logic        ovf;
  logic        mismatch;
  logic [33:0] new_bits;
  logic [95:0] win;
  logic [31:0] word_out;

  assign up.in_ready = !rst && (seq != 6'd32);
  assign accept      = up.in_ready;

  // The window is only 96 bits wide: its top two bits could only ever be set
  // when fill would exceed 64, and those newest bits are clamped away anyway.
  always_comb begin
    new_bits = '0;
    new_len  = '0;
    if (accept) begin
      if (up.header_ena) begin
        new_bits = {up.data, up.header};
        new_len  = 7'd34;
      end else begin
        new_bits = {2'b00, up.data};
        new_len  = 7'd32;
      end
    end
    win      = {32'b0, bits_q} | ({62'b0, new_bits} << fill_q);
    win_len  = fill_q + new_len;
    emit     = (win_len >= 7'd32);
    rest_len = emit ? (win_len - 7'd32) : win_len;
    bits_d   = emit ? win[95:32] : win[63:0];
    ovf      = (rest_len > 7'd64);
    fill_d   = ovf ? 7'd64 : rest_len;
    mismatch = accept && (up.header_ena != exp_first_q);
  end

  always_comb begin
    word_out = win[31:0];
    if (BIT_REVERSE) begin
      for (int i = 0; i < 32; i++) word_out[i] = win[31 - i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq         <= 6'd32;
      bits_q      <= '0;
      fill_q      <= '0;
      exp_first_q <= 1'b1;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      phase_err   <= 1'b0;
    end else begin
      seq       <= (seq == 6'd32) ? 6'd0 : seq + 6'd1;
      bits_q    <= bits_d;
      fill_q    <= fill_d;
      tx_valid  <= emit;
      phase_err <= mismatch || ovf;
      if (emit) tx_data <= word_out;
      // header_ena is authoritative: the half after a header is always a second half
      if (accept) exp_first_q <= !up.header_ena;
    end
  end

endmodule

// File: tb/tb_gearbox_tx.sv
// Self-checking bench for gearbox_tx against a bit-queue reference model.
module tb_gearbox_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gearbox_tx_if g_if ();
  gearbox_tx_if r_if ();

  logic [31:0] tx_data, r_tx_data;
  logic        tx_valid, r_tx_valid, phase_err, r_phase_err;
  logic [5:0]  seq, r_seq;

  gearbox_tx #(.BIT_REVERSE(1'b0)) dut (
    .clk(clk), .rst(rst), .up(g_if.slave),
    .tx_data(tx_data), .tx_valid(tx_valid), .seq(seq), .phase_err(phase_err)
  );

  gearbox_tx #(.BIT_REVERSE(1'b1)) dut_rev (
    .clk(clk), .rst(rst), .up(r_if.slave),
    .tx_data(r_tx_data), .tx_valid(r_tx_valid), .seq(r_seq), .phase_err(r_phase_err)
  );

  assign r_if.header     = 2'b01;
  assign r_if.header_ena = 1'b1;
  assign r_if.data       = 32'h0;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: the transmitted bit stream is a plain queue
  int          m_seq;
  bit          m_q[$];
  bit          m_exp_first;
  bit          m_valid;
  logic [31:0] m_data;
  bit          m_perr;
  bit          src_first;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_cycle(input logic r, input logic he, input logic [1:0] h, input logic [31:0] d);
    bit acc;
    rst = r;
    g_if.header_ena = he;
    g_if.header     = h;
    g_if.data       = d;
    @(posedge clk);
    if (r) begin
      m_seq = 32; m_q.delete(); m_exp_first = 1; m_valid = 0; m_data = '0; m_perr = 0;
    end else begin
      acc    = (m_seq != 32);
      m_perr = 0;
      if (acc) begin
        if (he != m_exp_first) m_perr = 1;
        m_exp_first = !he;
        if (he) begin m_q.push_back(h[0]); m_q.push_back(h[1]); end
        for (int i = 0; i < 32; i++) m_q.push_back(d[i]);
      end
      if (m_q.size() >= 32) begin
        m_valid = 1;
        for (int i = 0; i < 32; i++) m_data[i] = m_q.pop_front();
      end else begin
        m_valid = 0;
      end
      if (m_q.size() > 64) begin
        m_perr = 1;
        while (m_q.size() > 64) void'(m_q.pop_back());
      end
      m_seq = (m_seq + 1) % 33;
    end
    @(negedge clk);
  endtask

  // well-behaved source: alternating halves on ready cycles, junk otherwise
  task automatic src_cycle(input bit force_hdr);
    logic       he;
    logic [1:0] h;
    logic [31:0] d;
    h = 2'($urandom_range(1, 2));
    d = $urandom;
    if (m_seq != 32) begin
      he = force_hdr ? 1'b1 : src_first;
      src_first = !he;
    end else begin
      he = 1'($urandom_range(0, 1));
    end
    drive_cycle(1'b0, he, h, d);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, 1'b1, 2'b01, 32'h0);
      n_checks++;
      if ({g_if.in_ready, seq, tx_valid, phase_err} !== {1'b0, 6'd32, 1'b0, 1'b0})
        $display("FAIL reset_state: got rdy=%b seq=%0d v=%b perr=%b want rdy=0 seq=32 v=0 perr=0",
                 g_if.in_ready, seq, tx_valid, phase_err);
      else n_pass++;
    end
    n_checks++;
    if (tx_data !== 32'h0) $display("FAIL reset_data: got %h want 00000000", tx_data);
    else n_pass++;
    drive_cycle(1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF);
    n_checks++;
    if ({g_if.in_ready, seq, tx_valid} !== {1'b1, 6'd0, 1'b0})
      $display("FAIL release: got rdy=%b seq=%0d v=%b want rdy=1 seq=0 v=0", g_if.in_ready, seq, tx_valid);
    else n_pass++;
    src_first = 1;
  endtask

  task automatic test_first_word();
    drive_cycle(1'b0, 1'b1, 2'b01, 32'h0);
    n_checks++;
    if ({tx_valid, tx_data} !== {1'b1, 32'h0000_0001})
      $display("FAIL first_word: got v=%b %h want v=1 00000001", tx_valid, tx_data);
    else n_pass++;
    drive_cycle(1'b0, 1'b0, 2'b00, 32'h0);
    n_checks++;
    if ({tx_valid, tx_data, phase_err} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL second_word: got v=%b %h perr=%b want v=1 00000000 perr=0", tx_valid, tx_data, phase_err);
    else n_pass++;
    src_first = 1;
  endtask

  task automatic run_compare(input string name, input int cycles, input int force_seq);
    logic exp_rdy;
    bit   frc;
    for (int c = 0; c < cycles; c++) begin
      frc = (m_seq == force_seq);
      src_cycle(frc);
      exp_rdy = (m_seq != 32);
      n_checks++;
      if ({g_if.in_ready, seq, tx_valid, phase_err} !== {exp_rdy, m_seq[5:0], m_valid, m_perr})
        $display("FAIL %s_ctl c%0d: got rdy=%b seq=%0d v=%b perr=%b want rdy=%b seq=%0d v=%b perr=%b",
                 name, c, g_if.in_ready, seq, tx_valid, phase_err, exp_rdy, m_seq, m_valid, m_perr);
      else n_pass++;
      if (m_valid) begin
        n_checks++;
        if (tx_data !== m_data) $display("FAIL %s_data c%0d: got %h want %h", name, c, tx_data, m_data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stream();
    run_compare("stream", 99, -1);
  endtask

  task automatic test_pattern();
    drive_cycle(1'b1, 1'b0, 2'b00, 32'h0);
    drive_cycle(1'b0, 1'b0, 2'b00, 32'h0);
    drive_cycle(1'b0, 1'b1, 2'b10, 32'hFFFF_FFFF);
    n_checks++;
    if (tx_data !== 32'hFFFF_FFFE) $display("FAIL pattern_w0: got %h want fffffffe", tx_data);
    else n_pass++;
    drive_cycle(1'b0, 1'b0, 2'b00, 32'h0);
    n_checks++;
    if (tx_data !== 32'h0000_0003) $display("FAIL pattern_w1: got %h want 00000003", tx_data);
    else n_pass++;
    drive_cycle(1'b0, 1'b1, 2'b00, 32'h0);
    n_checks++;
    if ({tx_valid, tx_data} !== {1'b1, 32'h0}) $display("FAIL pattern_w2: got v=%b %h want v=1 00000000", tx_valid, tx_data);
    else n_pass++;
    src_first = 0;
    run_compare("pattern", 40, -1);
  endtask

  task automatic test_phase_err();
    int hits;
    drive_cycle(1'b1, 1'b0, 2'b00, 32'h0);
    src_first = 1;
    run_compare("pre_err", 6, -1);
    hits = 0;
    for (int c = 0; c < 3; c++) begin
      run_compare("err", 1, 5);
      if (phase_err === 1'b1) hits++;
    end
    n_checks++;
    if (hits != 1) $display("FAIL phase_err_pulses: got %0d want 1", hits);
    else n_pass++;
    run_compare("resync", 80, -1);
  endtask

  task automatic test_overflow();
    drive_cycle(1'b1, 1'b0, 2'b00, 32'h0);
    for (int c = 0; c < 70; c++) run_compare("ovf", 1, m_seq);
  endtask

  task automatic test_reset_mid();
    int budget;
    drive_cycle(1'b1, 1'b0, 2'b00, 32'h0);
    src_first = 1;
    budget = 0;
    while (m_seq != 17 && budget < 40) begin
      run_compare("pre_rst", 1, -1);
      budget++;
    end
    n_checks++;
    if (seq !== 6'd17) $display("FAIL reach_seq17: got %0d want 17", seq);
    else n_pass++;
    drive_cycle(1'b1, 1'b1, 2'b01, $urandom);
    n_checks++;
    if ({g_if.in_ready, seq, tx_valid, phase_err} !== {1'b0, 6'd32, 1'b0, 1'b0})
      $display("FAIL mid_reset: got rdy=%b seq=%0d v=%b perr=%b want rdy=0 seq=32 v=0 perr=0",
               g_if.in_ready, seq, tx_valid, phase_err);
    else n_pass++;
    src_first = 1;
    run_compare("restart", 40, -1);
  endtask

  task automatic test_bit_reverse();
    bit seen;
    drive_cycle(1'b1, 1'b0, 2'b00, 32'h0);
    drive_cycle(1'b1, 1'b0, 2'b00, 32'h0);
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      drive_cycle(1'b0, 1'b0, 2'b00, 32'h0);
      if (r_tx_valid === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) $display("FAIL rev_valid: got v=%b want v=1 within 6 cycles", r_tx_valid);
    else n_pass++;
    n_checks++;
    if (r_tx_data !== 32'h8000_0000) $display("FAIL rev_w0: got %h want 80000000", r_tx_data);
    else n_pass++;
    drive_cycle(1'b0, 1'b0, 2'b00, 32'h0);
    n_checks++;
    if (r_tx_data !== 32'h2000_0000) $display("FAIL rev_w1: got %h want 20000000", r_tx_data);
    else n_pass++;
  endtask

  initial begin
    g_if.header_ena = 1'b0;
    g_if.header     = 2'b00;
    g_if.data       = 32'h0;
    m_seq = 32; m_exp_first = 1; m_valid = 0; m_data = '0; m_perr = 0; src_first = 1;
    @(negedge clk);
    test_reset();
    test_first_word();
    test_stream();
    test_pattern();
    test_phase_err();
    test_overflow();
    test_reset_mid();
    test_bit_reverse();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
